// File: rtl/floor_request_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : elevator_pkg                                                   |
// | Purpose   : Shared types, default sizes and floor-search helpers for the   |
// |             floor request scheduler (SCAN elevator controller).            |
// | Contents  : state_t enum {IDLE, MOVE, DOOR}; DEF_NUM_FLOORS, DEF_FLOOR_W;  |
// |             any_above(), any_below().                                      |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package elevator_pkg;

  localparam int DEF_NUM_FLOORS = 10;
  localparam int DEF_FLOOR_W    = 4;

  // Helpers take a fixed-width call vector so they serve any floor count up
  // to this limit; callers zero-extend their pending set.
  localparam int MAX_FLOORS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  // True when any call is strictly above 'floor'. A shift by 32 yields zero,
  // so the mask correctly becomes all-ones for the topmost index.
  function automatic logic any_above(input logic [MAX_FLOORS-1:0] pend,
                                     input int unsigned           floor);
    logic [MAX_FLOORS-1:0] at_or_below;
    at_or_below = (MAX_FLOORS'(1) << (floor + 1)) - MAX_FLOORS'(1);
    return |(pend & ~at_or_below);
  endfunction

  // True when any call is strictly below 'floor'.
  function automatic logic any_below(input logic [MAX_FLOORS-1:0] pend,
                                     input int unsigned           floor);
    logic [MAX_FLOORS-1:0] below;
    below = (MAX_FLOORS'(1) << floor) - MAX_FLOORS'(1);
    return |(pend & below);
  endfunction

endpackage
`default_nettype wire

// File: rtl/floor_request_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : floor_request_scheduler_if                                     |
// | Purpose   : Bundles the call buttons and car status of the elevator        |
// |             controller.                                                    |
// | Signals   : call_in   - level floor-call buttons, bit f = floor f          |
// |             floorLED  - current car floor, binary                          |
// |             dir_up    - travel direction (1 = up)                          |
// |             moving    - car is stepping between floors                     |
// |             door_open - door held open at a serviced floor                 |
// |             pending   - outstanding, not-yet-serviced calls                |
// | Modports  : master = call panel / status reader, slave = scheduler         |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface floor_request_scheduler_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
);

  logic [NUM_FLOORS-1:0] call_in;
  logic [FLOOR_W-1:0]    floorLED;
  logic                  dir_up;
  logic                  moving;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;

  modport master (
    output call_in,
    input  floorLED, dir_up, moving, door_open, pending
  );

  modport slave (
    input  call_in,
    output floorLED, dir_up, moving, door_open, pending
  );

endinterface
`default_nettype wire

// File: rtl/floor_request_scheduler_cycle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : cycle_timer                                                    |
// | Purpose   : Loadable down-counter shared by the floor-step timing and the  |
// |             door dwell. done_o is high whenever the count is zero.         |
// | Ports     : clk, reset    - clock, synchronous active-high reset           |
// |             load_i        - load load_val_i (has priority over counting)   |
// |             load_val_i    - value loaded; load N-1 for an N-cycle interval |
// |             done_o        - count has reached zero                         |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module cycle_timer
  import elevator_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             load_i,
  input  wire logic [WIDTH-1:0] load_val_i,
  output logic                  done_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign done_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/floor_request_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : floor_request_scheduler                                        |
// | Purpose   : SCAN elevator car controller. Latches floor calls, keeps the   |
// |             travel direction while calls remain ahead, steps the car one   |
// |             floor per MOVE_CYCLES and holds the door for DWELL_CYCLES.     |
// | Ports     : clk   - system clock                                           |
// |             reset - synchronous, active-high reset                         |
// |             bus   - floor_request_scheduler_if.slave (call_in in;          |
// |                     floorLED, dir_up, moving, door_open, pending out)      |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module floor_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = DEF_NUM_FLOORS,
  parameter int FLOOR_W      = DEF_FLOOR_W,
  parameter int MOVE_CYCLES  = 2,
  parameter int DWELL_CYCLES = 4
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  floor_request_scheduler_if.slave  bus
);

  localparam int TIMER_MAX = (MOVE_CYCLES > DWELL_CYCLES) ? MOVE_CYCLES : DWELL_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0] C_MOVE_LOAD  = TIMER_W'(MOVE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] C_DWELL_LOAD = TIMER_W'(DWELL_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] C_TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

  state_t                state_q,   state_d;
  logic [FLOOR_W-1:0]    floor_q,   floor_d;
  logic                  dir_q,     dir_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] clr;

  logic                  tmr_load;
  logic [TIMER_W-1:0]    tmr_val;
  logic                  tmr_done;

  logic                  calls_above;
  logic                  calls_below;

  cycle_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign calls_above = any_above(MAX_FLOORS'(pending_q), 32'(floor_q));
  assign calls_below = any_below(MAX_FLOORS'(pending_q), 32'(floor_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state_q)
      IDLE: begin
        // Decisions use the registered pending set only, never call_in.
        if (pending_q != '0) begin
          if (pending_q[floor_q]) begin
            state_d  = DOOR;
            tmr_load = 1'b1;
            tmr_val  = C_DWELL_LOAD;
          end else begin
            if (dir_q && calls_above) begin
              dir_d = 1'b1;
            end else if (calls_below) begin
              dir_d = 1'b0;
            end else begin
              dir_d = 1'b1;
            end
            state_d  = MOVE;
            tmr_load = 1'b1;
            tmr_val  = C_MOVE_LOAD;
          end
        end
      end

      MOVE: begin
        if (tmr_done) begin
          // Saturation guard: a step past either end parks the car instead.
          if (dir_q ? (floor_q == C_TOP_FLOOR) : (floor_q == '0)) begin
            state_d = IDLE;
          end else begin
            floor_d = dir_q ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));
            tmr_load = 1'b1;
            if (pending_q[floor_d]) begin
              state_d = DOOR;
              tmr_val = C_DWELL_LOAD;
            end else begin
              tmr_val = C_MOVE_LOAD;
            end
          end
        end
      end

      DOOR: begin
        if (tmr_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The serviced floor is cleared on the edge that opens the door and on
    // every dwell edge, so it beats any simultaneous call to that floor.
    if ((state_d == DOOR) || (state_q == DOOR)) begin
      clr = NUM_FLOORS'(1) << floor_d;
    end else begin
      clr = '0;
    end
    pending_d = (pending_q | bus.call_in) & ~clr;
  end

  assign bus.floorLED  = floor_q;
  assign bus.dir_up    = dir_q;
  assign bus.moving    = (state_q == MOVE);
  assign bus.door_open = (state_q == DOOR);
  assign bus.pending   = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_floor_request_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_floor_request_scheduler                                     |
// | Purpose   : Self-checking bench for floor_request_scheduler: directed      |
// |             scenarios with literal expectations plus randomized calls      |
// |             checked every cycle against a behavioural elevator model.      |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_floor_request_scheduler;
  import elevator_pkg::*;

  localparam int NF    = 10;
  localparam int FW    = 4;
  localparam int MOVE  = 2;
  localparam int DWELL = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  floor_request_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

  floor_request_scheduler #(
    .NUM_FLOORS   (NF),
    .FLOOR_W      (FW),
    .MOVE_CYCLES  (MOVE),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The car is either parked, travelling (counting cycles since the last
  // floor), or dwelling (counting cycles since the door opened).
  int      m_floor   = 0;
  bit      m_up      = 1'b1;
  bit [NF-1:0] m_pend = '0;
  int      m_mode    = 0;   // 0 parked, 1 travelling, 2 dwelling
  int      m_elapsed = 0;

  task automatic model_step(input bit [NF-1:0] calls, input bit rst);
    bit clr_here;
    bit hi, lo;
    int nf;
    bit [NF-1:0] nxt;
    if (rst) begin
      m_floor = 0; m_up = 1'b1; m_pend = '0; m_mode = 0; m_elapsed = 0;
      return;
    end
    clr_here = 1'b0;
    case (m_mode)
      0: begin
        if (m_pend != '0) begin
          if (m_pend[m_floor]) begin
            m_mode = 2; m_elapsed = 0; clr_here = 1'b1;
          end else begin
            hi = 1'b0; lo = 1'b0;
            for (int f = 0; f < NF; f++) begin
              if (m_pend[f] && f > m_floor) hi = 1'b1;
              if (m_pend[f] && f < m_floor) lo = 1'b1;
            end
            if (!(m_up && hi)) m_up = !lo;
            m_mode = 1; m_elapsed = 0;
          end
        end
      end
      1: begin
        m_elapsed++;
        if (m_elapsed == MOVE) begin
          m_elapsed = 0;
          nf = m_up ? m_floor + 1 : m_floor - 1;
          if (nf < 0 || nf > NF - 1) begin
            m_mode = 0;
          end else begin
            m_floor = nf;
            if (m_pend[m_floor]) begin
              m_mode = 2; clr_here = 1'b1;
            end
          end
        end
      end
      default: begin
        m_elapsed++;
        clr_here = 1'b1;
        if (m_elapsed == DWELL) m_mode = 0;
      end
    endcase
    nxt = m_pend | calls;
    if (clr_here) nxt[m_floor] = 1'b0;
    m_pend = nxt;
  endtask

  // Model advances with the same inputs the DUT sampled; compare 1 time unit later.
  initial begin
    bit [NF-1:0] c;
    bit r;
    logic [31:0] act, exp;
    forever begin
      @(posedge clk);
      c = bus.call_in;
      r = reset;
      #1;
      model_step(c, r);
      if (check_en) begin
        act = {14'd0, bus.floorLED, bus.dir_up, bus.moving, bus.door_open, bus.pending};
        exp = {14'd0, 4'(m_floor), m_up, (m_mode == 1), (m_mode == 2), m_pend};
        chk("cycle_outputs", act, exp);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic pulse_call(input logic [NF-1:0] calls);
    bus.call_in = calls;
    @(negedge clk);
    bus.call_in = '0;
  endtask

  task automatic wait_door(input logic val, input int budget, input string name);
    int n = 0;
    while (bus.door_open !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(bus.door_open), 32'(val));
  endtask

  initial begin
    bus.call_in = '0;
    reset = 1'b1;

    // 1. reset held two cycles
    repeat (2) @(negedge clk);
    chk("rst_floor",   32'(bus.floorLED),  0);
    chk("rst_dir",     32'(bus.dir_up),    1);
    chk("rst_moving",  32'(bus.moving),    0);
    chk("rst_door",    32'(bus.door_open), 0);
    chk("rst_pending", 32'(bus.pending),   0);
    reset = 1'b0;
    check_en = 1'b1;
    @(negedge clk);

    // 2. single call to floor 1 from floor 0
    pulse_call(10'h002);
    chk("t2_pending", 32'(bus.pending), 32'h002);
    repeat (3) @(negedge clk);
    chk("t2_floor",  32'(bus.floorLED),  1);
    chk("t2_door",   32'(bus.door_open), 1);
    repeat (3) @(negedge clk);
    chk("t2_door_last", 32'(bus.door_open), 1);
    @(negedge clk);
    chk("t2_door_closed", 32'(bus.door_open), 0);
    chk("t2_pending_clr", 32'(bus.pending),   0);

    // 3. calls at 0 and 3 from floor 1 heading up
    pulse_call(10'h009);
    wait_door(1'b1, 40, "t3_open3");
    chk("t3_floor3", 32'(bus.floorLED), 3);
    wait_door(1'b0, 20, "t3_close3");
    wait_door(1'b1, 40, "t3_open0");
    chk("t3_floor0", 32'(bus.floorLED), 0);
    chk("t3_dir",    32'(bus.dir_up),   0);
    wait_door(1'b0, 20, "t3_close0");
    chk("t3_pending", 32'(bus.pending), 0);

    // 4. call 4, then call 2 inserted while passing floor 1
    pulse_call(10'h010);
    for (int i = 0; i < 20 && bus.floorLED != 1; i++) @(negedge clk);
    chk("t4_at1", 32'(bus.floorLED), 1);
    pulse_call(10'h004);
    wait_door(1'b1, 20, "t4_open2");
    chk("t4_floor2", 32'(bus.floorLED), 2);
    wait_door(1'b0, 20, "t4_close2");
    wait_door(1'b1, 20, "t4_open4");
    chk("t4_floor4", 32'(bus.floorLED), 4);
    wait_door(1'b0, 20, "t4_close4");

    // 5. go to floor 2, then call the current floor
    pulse_call(10'h004);
    wait_door(1'b1, 40, "t5_open_a");
    wait_door(1'b0, 20, "t5_close_a");
    chk("t5_floor2", 32'(bus.floorLED), 2);
    pulse_call(10'h004);
    chk("t5_pending", 32'(bus.pending), 32'h004);
    @(negedge clk);
    chk("t5_door",     32'(bus.door_open), 1);
    chk("t5_nomove",   32'(bus.moving),    0);
    chk("t5_same_fl",  32'(bus.floorLED),  2);
    pulse_call(10'h004);
    chk("t5_dropped",  32'(bus.pending),   0);
    repeat (3) @(negedge clk);
    chk("t5_closed",   32'(bus.door_open), 0);
    chk("t5_pend_end", 32'(bus.pending),   0);

    // 6. reset during a move
    pulse_call(10'h0A0);
    for (int i = 0; i < 20 && !(bus.floorLED == 3 && bus.moving); i++) @(negedge clk);
    chk("t6_at3_moving", 32'({bus.floorLED, bus.moving}), 32'({4'd3, 1'b1}));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_floor",   32'(bus.floorLED),  0);
    chk("t6_pending", 32'(bus.pending),   0);
    chk("t6_moving",  32'(bus.moving),    0);
    chk("t6_door",    32'(bus.door_open), 0);
    chk("t6_dir",     32'(bus.dir_up),    1);
    repeat (10) @(negedge clk);
    chk("t6_idle", 32'({bus.floorLED, bus.moving, bus.door_open}), 0);

    // Randomized calls and occasional resets, checked by the model each cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 15) == 0) bus.call_in = NF'($urandom);
        else bus.call_in = NF'(1) << $urandom_range(0, NF - 1);
      end else begin
        bus.call_in = '0;
      end
      reset = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    bus.call_in = '0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
